mac_sequencer: RTL and testbench



---
 rtl/mac_pkg.sv | 29 ++
 rtl/mac_sequencer_if.sv | 45 ++++
 rtl/mac_acc.sv | 50 +++++
 rtl/mac_sequencer.sv | 123 ++++++++++++
 tb/tb_mac_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC sequencer: FSM state encoding, operand and
// product field positions, and the default accumulator width.
// Optional feature macro used by this slice: MAC_SEQUENCER_SAT_EN.
package mac_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_LO,
        S_WAIT_HI,
        S_ACC,
        S_DONE
    } state_t;

    // 8-bit operand packing: [7:4] real, [3:0] imaginary (signed 4-bit each)
    localparam int OP_RE_HI = 7;
    localparam int OP_RE_LO = 4;
    localparam int OP_IM_HI = 3;
    localparam int OP_IM_LO = 0;

    // 16-bit product packing: [15:8] real, [7:0] imaginary (signed 8-bit each)
    localparam int PR_RE_HI = 15;
    localparam int PR_RE_LO = 8;
    localparam int PR_IM_HI = 7;
    localparam int PR_IM_LO = 0;

    localparam int DEF_ACC_W = 20;

endpackage

// File: rtl/mac_sequencer_if.sv
// Bus bundle of the MAC sequencer: operand stream in, multiplier start/ready
// link, result stream out, plus the FSM state for observation.
//
// Handshakes: a stream transfer happens on a rising clk edge where both valid
// and ready are high; valid-side signals stay stable while valid waits for
// ready. The multiplier link uses a one-cycle start pulse, issued only while
// mul_ready is high; mul_ready then drops and rises again with mul_out valid.
interface mac_sequencer_if
    import mac_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W
) ();

    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_a;
    logic [7:0]       in_b;
    logic             clr;
    logic             mul_start;
    logic [7:0]       mul_a;
    logic [7:0]       mul_b;
    logic             mul_ready;
    logic [15:0]      mul_out;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_re;
    logic [ACC_W-1:0] acc_im;
    logic             ovf;
    state_t           fsm_state;

    // Sequencer side
    modport master (
        input  in_valid, in_a, in_b, clr, mul_ready, mul_out, out_ready,
        output in_ready, mul_start, mul_a, mul_b, out_valid, acc_re, acc_im,
               ovf, fsm_state
    );

    // Environment side (operand source, multiplier, result consumer)
    modport slave (
        output in_valid, in_a, in_b, clr, mul_ready, mul_out, out_ready,
        input  in_ready, mul_start, mul_a, mul_b, out_valid, acc_re, acc_im,
               ovf, fsm_state
    );

endinterface

// File: rtl/mac_acc.sv
// Signed ACC_W accumulator for one component of the complex sum. Sign-extends
// an 8-bit product, adds it, and keeps a sticky overflow flag.
// MAC_SEQUENCER_SAT_EN defined: clamp to signed max/min on overflow;
// otherwise the sum wraps in two's complement.
module mac_acc #(
    parameter int ACC_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [7:0]       addend,
    output logic [ACC_W-1:0] acc,
    output logic             ovf
);

    logic [ACC_W-1:0] ext;
    logic [ACC_W-1:0] sum;
    logic             add_ovf;

    assign ext = ACC_W'($signed(addend));
    assign sum = acc + ext;
    // Same-sign operands whose sum flips sign have overflowed
    assign add_ovf = (acc[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);

`ifdef MAC_SEQUENCER_SAT_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

    // Accumulate on en, zero on clr; overflow stays set until cleared
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (en) begin
            ovf <= ovf | add_ovf;
`ifdef MAC_SEQUENCER_SAT_EN
            // Overflow direction follows the sign of the old accumulator
            acc <= add_ovf ? (acc[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum;
`else
            acc <= sum;
`endif
        end
    end

endmodule

// File: rtl/mac_sequencer.sv
// MAC sequencer: accepts packed complex operand pairs, issues each to the
// external complex multiplier, accumulates real/imag products and presents
// the sum after NTERMS products.
// Optional feature macro: MAC_SEQUENCER_SAT_EN (saturating accumulators).
module mac_sequencer
    import mac_pkg::*;
#(
    parameter int NTERMS = 4,
    parameter int ACC_W  = DEF_ACC_W
) (
    input logic             clk,
    input logic             rst,
    mac_sequencer_if.master bus
);

    localparam int CNT_W = (NTERMS > 1) ? $clog2(NTERMS) : 1;
    localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(NTERMS - 1);

    state_t           state;
    logic [CNT_W-1:0] term_cnt;
    logic [7:0]       op_a;
    logic [7:0]       op_b;
    logic [15:0]      prod;
    logic             mul_start_q;
    logic             acc_clr;
    logic             acc_en;
    logic [ACC_W-1:0] acc_re;
    logic [ACC_W-1:0] acc_im;
    logic             ovf_re;
    logic             ovf_im;

    // Sequencing FSM: operand capture, multiplier handshake, term counting
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            term_cnt    <= '0;
            op_a        <= '0;
            op_b        <= '0;
            prod        <= '0;
            mul_start_q <= 1'b0;
        end else begin
            mul_start_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    // A clear arriving with a pair restarts the sum at term 0
                    if (bus.clr) term_cnt <= '0;
                    if (bus.in_valid) begin
                        op_a  <= bus.in_a;
                        op_b  <= bus.in_b;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bus.mul_ready) begin
                        mul_start_q <= 1'b1;
                        state       <= S_WAIT_LO;
                    end
                end
                // Multiplier lowers ready one cycle after the start pulse
                S_WAIT_LO: begin
                    if (!bus.mul_ready) state <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (bus.mul_ready) begin
                        prod  <= bus.mul_out;
                        state <= S_ACC;
                    end
                end
                S_ACC: begin
                    if (term_cnt == LAST_TERM) begin
                        term_cnt <= '0;
                        state    <= S_DONE;
                    end else begin
                        term_cnt <= term_cnt + 1'b1;
                        state    <= S_IDLE;
                    end
                end
                S_DONE: begin
                    if (bus.clr) term_cnt <= '0;
                    if (bus.clr || bus.out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Clear only where no multiplier operation is in flight; the result
    // handshake also empties the accumulators for the next sum
    assign acc_clr = (bus.clr && (state == S_IDLE || state == S_DONE)) ||
                     (state == S_DONE && bus.out_ready);
    assign acc_en  = (state == S_ACC);

    mac_acc #(.ACC_W(ACC_W)) u_acc_re (
        .clk    (clk),
        .rst    (rst),
        .clr    (acc_clr),
        .en     (acc_en),
        .addend (prod[PR_RE_HI:PR_RE_LO]),
        .acc    (acc_re),
        .ovf    (ovf_re)
    );

    mac_acc #(.ACC_W(ACC_W)) u_acc_im (
        .clk    (clk),
        .rst    (rst),
        .clr    (acc_clr),
        .en     (acc_en),
        .addend (prod[PR_IM_HI:PR_IM_LO]),
        .acc    (acc_im),
        .ovf    (ovf_im)
    );

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.mul_start = mul_start_q;
    assign bus.mul_a     = op_a;
    assign bus.mul_b     = op_b;
    assign bus.acc_re    = acc_re;
    assign bus.acc_im    = acc_im;
    assign bus.ovf       = ovf_re | ovf_im;
    assign bus.fsm_state = state;

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: a wide (ACC_W=20) instance for accumulation,
// handshake, reset and clear behaviour, and a narrow (ACC_W=8) instance whose
// multiplier always returns +100 real for the overflow case.
module tb_mac_sequencer;
    import mac_pkg::*;

    localparam int M = 8;
`ifdef MAC_SEQUENCER_SAT_EN
    localparam int OVF_RE = 127;
`else
    localparam int OVF_RE = -112;
`endif

    typedef struct packed {
        logic signed [23:0] re;
        logic signed [23:0] im;
        logic               o;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mac_sequencer_if #(.ACC_W(20)) bus ();
    mac_sequencer_if #(.ACC_W(8))  bus8 ();

    mac_sequencer #(.NTERMS(4), .ACC_W(20)) u_dut (.clk(clk), .rst(rst), .bus(bus));
    mac_sequencer #(.NTERMS(4), .ACC_W(8))  u_ovf (.clk(clk), .rst(rst), .bus(bus8));

    logic mdl_ready, mdl8_ready, busy_hold;
    assign bus.mul_ready  = mdl_ready && !busy_hold;
    assign bus8.mul_ready = mdl8_ready;

    exp_t exp_q[$];
    exp_t exp8_q[$];
    int checks = 0;
    int errors = 0;
    int start_cnt = 0;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting, expected event", name);
    endtask

    function automatic logic [15:0] cmul(input logic [7:0] a, input logic [7:0] b);
        logic signed [3:0] ar, ai, br, bi;
        int re, im;
        ar = a[OP_RE_HI:OP_RE_LO];
        ai = a[OP_IM_HI:OP_IM_LO];
        br = b[OP_RE_HI:OP_RE_LO];
        bi = b[OP_IM_HI:OP_IM_LO];
        re = int'(ar) * int'(br) - int'(ai) * int'(bi);
        im = int'(ar) * int'(bi) + int'(ai) * int'(br);
        return {re[7:0], im[7:0]};
    endfunction

    // Behavioural complex multiplier, M cycles from start to ready
    logic [15:0] mdl_p;
    initial begin
        mdl_ready = 1'b1;
        bus.mul_out = '0;
        forever begin
            @(negedge clk);
            if (bus.mul_start === 1'b1) begin
                mdl_p = cmul(bus.mul_a, bus.mul_b);
                @(posedge clk); #1 mdl_ready = 1'b0;
                repeat (M - 1) @(posedge clk);
                #1;
                bus.mul_out = mdl_p;
                mdl_ready = 1'b1;
            end
        end
    end

    // Overflow multiplier: always real=+100, imag=0
    initial begin
        mdl8_ready = 1'b1;
        bus8.mul_out = '0;
        forever begin
            @(negedge clk);
            if (bus8.mul_start === 1'b1) begin
                @(posedge clk); #1 mdl8_ready = 1'b0;
                repeat (M - 1) @(posedge clk);
                #1;
                bus8.mul_out = 16'h6400;
                mdl8_ready = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bus.mul_start === 1'b1) start_cnt++;
        end
    end

    // Result monitors: pop one expectation when out_valid rises
    initial begin
        exp_t e;
        logic seen;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && bus.out_valid === 1'b1) begin
                if (!seen) begin
                    seen = 1'b1;
                    if (exp_q.size() == 0) check("unexpected_result", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        check("acc_re", $signed(bus.acc_re), e.re);
                        check("acc_im", $signed(bus.acc_im), e.im);
                        check("ovf", {31'd0, bus.ovf}, {31'd0, e.o});
                    end
                end
            end else seen = 1'b0;
        end
    end

    initial begin
        exp_t e;
        logic seen;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && bus8.out_valid === 1'b1) begin
                if (!seen) begin
                    seen = 1'b1;
                    if (exp8_q.size() == 0) check("unexpected_result8", 1, 0);
                    else begin
                        e = exp8_q.pop_front();
                        check("acc8_re", $signed(bus8.acc_re), e.re);
                        check("acc8_im", $signed(bus8.acc_im), e.im);
                        check("ovf8", {31'd0, bus8.ovf}, {31'd0, e.o});
                    end
                end
            end else seen = 1'b0;
        end
    end

    task automatic send_pair(input logic sel, input logic [7:0] a, input logic [7:0] b,
                             input logic with_clr);
        int n;
        n = 0;
        @(negedge clk);
        while (!(sel ? bus8.in_ready : bus.in_ready) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!(sel ? bus8.in_ready : bus.in_ready)) begin
            fail_timeout("send_wait_in_ready");
            return;
        end
        if (sel) begin
            bus8.in_valid = 1'b1; bus8.in_a = a; bus8.in_b = b; bus8.clr = with_clr;
        end else begin
            bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.clr = with_clr;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.clr = 1'b0;
        bus8.in_valid = 1'b0; bus8.clr = 1'b0;
    endtask

    task automatic wait_done(input logic sel);
        int n;
        n = 0;
        @(negedge clk);
        while (!(sel ? bus8.out_valid : bus.out_valid) && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (!(sel ? bus8.out_valid : bus.out_valid)) begin
            fail_timeout("wait_out_valid");
            return;
        end
        n = 0;
        while ((sel ? bus8.out_valid : bus.out_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_state(input state_t s);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.fsm_state != s && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (bus.fsm_state != s) fail_timeout("wait_state");
    endtask

    task automatic run4(input logic [7:0] a, input logic [7:0] b,
                        input int re, input int im);
        exp_q.push_back('{re: 24'(re), im: 24'(im), o: 1'b0});
        repeat (4) send_pair(1'b0, a, b, 1'b0);
        wait_done(1'b0);
    endtask

    initial begin
        int s0, early, bad, n;
        bus.in_valid = 0; bus.in_a = 0; bus.in_b = 0; bus.clr = 0; bus.out_ready = 1;
        bus8.in_valid = 0; bus8.in_a = 0; bus8.in_b = 0; bus8.clr = 0; bus8.out_ready = 1;
        busy_hold = 0;

        // Reset values
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_in_ready", {31'd0, bus.in_ready}, 1);
        check("rst_mul_start", {31'd0, bus.mul_start}, 0);
        check("rst_mul_a", {24'd0, bus.mul_a}, 0);
        check("rst_mul_b", {24'd0, bus.mul_b}, 0);
        check("rst_out_valid", {31'd0, bus.out_valid}, 0);
        check("rst_acc_re", $signed(bus.acc_re), 0);
        check("rst_acc_im", $signed(bus.acc_im), 0);
        check("rst_ovf", {31'd0, bus.ovf}, 0);

        // Basic, negative and extreme operand patterns
        s0 = start_cnt;
        run4(8'h12, 8'h31, 4, 28);
        check("basic_start_pulses", start_cnt - s0, 4);
        run4(8'hF1, 8'h2E, 0, 16);
        run4(8'hF0, 8'h30, -12, 0);
        run4(8'h77, 8'h88, 0, -448);

        // Back-pressure: result held while out_ready is low
        exp_q.push_back('{re: 24'sd4, im: 24'sd28, o: 1'b0});
        bus.out_ready = 1'b0;
        repeat (4) send_pair(1'b0, 8'h12, 8'h31, 1'b0);
        n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 600) begin @(negedge clk); n++; end
        if (!bus.out_valid) fail_timeout("bp_out_valid");
        bus.in_valid = 1'b1; bus.in_a = 8'h12; bus.in_b = 8'h31;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.ovf !== 1'b0 ||
                $signed(bus.acc_re) !== 4 || $signed(bus.acc_im) !== 28) bad++;
        end
        check("bp_hold_stable", bad, 0);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_after_acc_re", $signed(bus.acc_re), 0);
        check("bp_after_acc_im", $signed(bus.acc_im), 0);
        check("bp_after_out_valid", {31'd0, bus.out_valid}, 0);
        check("bp_after_in_ready", {31'd0, bus.in_ready}, 1);

        // Multiplier busy on entry to ISSUE
        s0 = start_cnt;
        exp_q.push_back('{re: 24'sd0, im: 24'sd16, o: 1'b0});
        send_pair(1'b0, 8'hF1, 8'h2E, 1'b0);
        busy_hold = 1'b1;
        early = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.mul_start === 1'b1) early++;
        end
        check("busy_no_start", early, 0);
        check("busy_in_issue", int'(bus.fsm_state), int'(S_ISSUE));
        busy_hold = 1'b0;
        repeat (3) send_pair(1'b0, 8'hF1, 8'h2E, 1'b0);
        wait_done(1'b0);
        check("busy_start_pulses", start_cnt - s0, 4);

        // Overflow on the narrow instance
        exp8_q.push_back('{re: 24'(OVF_RE), im: 24'sd0, o: 1'b1});
        repeat (4) send_pair(1'b1, 8'h12, 8'h31, 1'b0);
        wait_done(1'b1);

        // Reset during WAIT_HI discards the partial sum
        send_pair(1'b0, 8'h12, 8'h31, 1'b0);
        send_pair(1'b0, 8'h12, 8'h31, 1'b0);
        send_pair(1'b0, 8'h12, 8'h31, 1'b0);
        wait_state(S_WAIT_HI);
        rst = 1'b0;
        #1;
        check("mid_rst_in_ready", {31'd0, bus.in_ready}, 1);
        check("mid_rst_mul_start", {31'd0, bus.mul_start}, 0);
        check("mid_rst_mul_a", {24'd0, bus.mul_a}, 0);
        check("mid_rst_out_valid", {31'd0, bus.out_valid}, 0);
        check("mid_rst_acc_re", $signed(bus.acc_re), 0);
        check("mid_rst_acc_im", $signed(bus.acc_im), 0);
        check("mid_rst_ovf", {31'd0, bus.ovf}, 0);
        @(negedge clk);
        rst = 1'b1;
        run4(8'h12, 8'h31, 4, 28);

        // clr during WAIT_LO is ignored
        exp_q.push_back('{re: 24'sd4, im: 24'sd28, o: 1'b0});
        send_pair(1'b0, 8'h12, 8'h31, 1'b0);
        send_pair(1'b0, 8'h12, 8'h31, 1'b0);
        wait_state(S_WAIT_LO);
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        repeat (2) send_pair(1'b0, 8'h12, 8'h31, 1'b0);
        wait_done(1'b0);

        // clr in IDLE after two terms zeroes accumulators and term count
        send_pair(1'b0, 8'h12, 8'h31, 1'b0);
        send_pair(1'b0, 8'h12, 8'h31, 1'b0);
        wait_state(S_IDLE);
        check("pre_clr_acc_re", $signed(bus.acc_re), 2);
        check("pre_clr_acc_im", $signed(bus.acc_im), 14);
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        check("clr_idle_acc_re", $signed(bus.acc_re), 0);
        check("clr_idle_acc_im", $signed(bus.acc_im), 0);
        run4(8'h12, 8'h31, 4, 28);

        // clr together with in_valid: pair becomes term 0 of a fresh sum
        send_pair(1'b0, 8'hF1, 8'h2E, 1'b0);
        send_pair(1'b0, 8'hF1, 8'h2E, 1'b0);
        exp_q.push_back('{re: 24'sd4, im: 24'sd28, o: 1'b0});
        send_pair(1'b0, 8'h12, 8'h31, 1'b1);
        repeat (3) send_pair(1'b0, 8'h12, 8'h31, 1'b0);
        wait_done(1'b0);

        repeat (3) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);
        check("exp8_q_drained", exp8_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
